pipeline_skid_reg: RTL and testbench
====================================

PIPELINE_SKID_REG -- requirements
Module: pipeline_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of each data payload word.
REQ-002 Parameter CTRL_W, default 4: width of the control-bit payload, e.g. REG_WRITE plus MEM_TO_REG plus spare.
REQ-003 Parameter ADDR_W, default 5: width of the destination register address.
REQ-004 Parameter NDATA, default 3: number of DATA_W words carried, e.g. ALU result, read data and next PC.
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 RESET  in  1  asynchronous, active-low reset.
REQ-007 BUSY_WAIT  in  1  global stall; when 1, no accept and no emit occur.
REQ-008 FLUSH  in  1  synchronous discard of all buffered entries.
REQ-009 IN_VALID  in  1  upstream entry present.
REQ-010 IN_READY  out  1  stage can accept; driven directly from a flop.
REQ-011 IN_CTRL  in  CTRL_W  control payload.
REQ-012 IN_ADDR  in  ADDR_W  destination register address.
REQ-013 IN_DATA  in  NDATA*DATA_W  packed data payload; word 0 occupies the LSBs.
REQ-014 OUT_VALID  out  1  head entry present.
REQ-015 OUT_READY  in  1  downstream takes head.
REQ-016 OUT_CTRL, OUT_ADDR, OUT_DATA  out  CTRL_W, ADDR_W, NDATA*DATA_W  head entry fields.
REQ-017 OCC  out  2  number of buffered entries (0..2).

Function
REQ-018 Accept SHALL occur on a cycle where IN_VALID & IN_READY & !BUSY_WAIT & !FLUSH are all true.
REQ-019 Emit SHALL occur on a cycle where OUT_VALID & OUT_READY & !BUSY_WAIT & !FLUSH are all true.
REQ-020 The block SHALL implement states EMPTY (OCC=0), ONE (main register full, OCC=1) and TWO (main and skid registers full, OCC=2).
REQ-021 EMPTY: on accept, main<=input and go to ONE; otherwise hold.
REQ-022 ONE: on accept and emit together, main<=input and stay in ONE; accept only: skid<=input, go to TWO; emit only: go to EMPTY.
REQ-023 TWO: on emit, main<=skid and go to ONE; accept is impossible in this state.
REQ-024 OUT_* fields SHALL always reflect the main register; OUT_VALID SHALL be 1 exactly when the state is not EMPTY.
REQ-025 IN_READY SHALL be a registered copy of (next state != TWO), with no combinational path from OUT_READY.
REQ-026 Latency: an entry accepted into an EMPTY stage SHALL appear on OUT_* with OUT_VALID=1 one cycle later.
REQ-027 Throughput: with OUT_READY held at 1, the stage SHALL sustain one entry per cycle.
REQ-028 Ordering SHALL be strict FIFO; no entry is duplicated or dropped except by FLUSH or reset.
REQ-029 BUSY_WAIT=1 SHALL freeze state, payload registers, OCC and IN_READY.
REQ-030 FLUSH=1 SHALL force the state to EMPTY and clear OUT_CTRL to 0 on the next edge, regardless of BUSY_WAIT, IN_VALID or OUT_READY; IN_READY SHALL become 1 on that edge.
REQ-031 When FLUSH is asserted, an entry offered that same cycle SHALL NOT be captured.
REQ-032 Data and address registers are not required to be cleared by FLUSH; only the state and OUT_CTRL are cleared.

Reset
REQ-033 While RESET=0, all flops SHALL clear immediately: state EMPTY, main, skid and OUT_* all 0, OCC=0, IN_READY=1.
REQ-034 A reset asserted mid-operation SHALL discard all entries; the first edge after release SHALL behave as from EMPTY.

Structure
REQ-035 The state encoding (EMPTY, ONE, TWO) and the default widths SHALL be placed in the shared CPU package.
REQ-036 A single sub-module, pipe_payload_reg, SHALL hold one {ctrl, addr, data} entry with a load enable, and SHALL be instantiated twice (main and skid).

Verification
REQ-037 Reset, then pass entries A=0x11, B=0x22 and C=0x33 with OUT_READY=1 -> OUT_DATA shows A, B, C on consecutive cycles; OCC=1 throughout.
REQ-038 OUT_READY=0 while A and B are offered -> OCC reaches 2 and IN_READY drops to 0; set OUT_READY=1 -> A then B are emitted and IN_READY returns to 1 one cycle after the first emit.
REQ-039 BUSY_WAIT=1 for 3 cycles with OCC=1 and IN_VALID=1 -> outputs, OCC and IN_READY are unchanged, and no capture occurs.
REQ-040 OCC=2, then FLUSH=1 with IN_VALID=1 (D=0x44) -> next cycle OUT_VALID=0, OUT_CTRL=0, OCC=0, IN_READY=1, and D is absent.
REQ-041 RESET pulsed low asynchronously mid-cycle with OCC=2 -> outputs go to 0 before the next edge; after release, the next accepted entry appears one cycle later.
REQ-042 Random IN_VALID, OUT_READY and BUSY_WAIT for 10k cycles against a FIFO scoreboard (NDATA=2, DATA_W=16) -> zero ordering or loss errors.

Source files
------------

// File: rtl/pipeline_skid_reg_pkg.sv
// Shared CPU pipeline definitions: skid-stage state encoding and default payload widths.
package pipeline_skid_reg_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 4;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NDATA  = 3;

    // Encoding equals the number of buffered entries, so OCC is the state value.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    function automatic logic [1:0] state_occ(input skid_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipeline_skid_reg_payload.sv
// One {ctrl, addr, data} pipeline entry with load enable; ctrl can be cleared independently.
module pipe_payload_reg #(
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NDATA  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    clear_ctrl,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [NDATA*DATA_W-1:0] in_data,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [NDATA*DATA_W-1:0] out_data
);

    logic [CTRL_W-1:0] ctrl_reg;
    logic [ADDR_W-1:0] addr_reg;

    // Clearing ctrl (REG_WRITE etc.) is enough to turn a stale entry into a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg <= '0;
            addr_reg <= '0;
        end else if (clear_ctrl) begin
            ctrl_reg <= '0;
        end else if (load) begin
            ctrl_reg <= in_ctrl;
            addr_reg <= in_addr;
        end
    end

    generate
        for (genvar gi = 0; gi < NDATA; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (load && !clear_ctrl) begin
                    word_reg <= in_data[gi*DATA_W +: DATA_W];
                end
            end
            assign out_data[gi*DATA_W +: DATA_W] = word_reg;
        end
    endgenerate

    assign out_ctrl = ctrl_reg;
    assign out_addr = addr_reg;

endmodule

// File: rtl/pipeline_skid_reg.sv
// Two-entry skid pipeline register: full throughput with in_ready taken straight from a flop.
module pipeline_skid_reg
    import pipeline_skid_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NDATA  = DEF_NDATA
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    busy_wait,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [NDATA*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [NDATA*DATA_W-1:0] out_data,
    output logic [1:0]              occ
);

    skid_state_t state_reg, state_next;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic [1:0]  occ_reg;

    logic accept, emit;
    logic main_load, skid_load;

    logic [CTRL_W-1:0]       skid_ctrl, main_src_ctrl;
    logic [ADDR_W-1:0]       skid_addr, main_src_addr;
    logic [NDATA*DATA_W-1:0] skid_data, main_src_data;

    assign accept = in_valid  && in_ready_reg  && !busy_wait && !flush;
    assign emit   = out_ready && out_valid_reg && !busy_wait && !flush;

    always_comb begin
        state_next = state_reg;
        main_load  = 1'b0;
        skid_load  = 1'b0;
        unique case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_ONE;
                    main_load  = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    main_load  = 1'b1;
                end else if (accept) begin
                    state_next = ST_TWO;
                    skid_load  = 1'b1;
                end else if (emit) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (emit) begin
                    state_next = ST_ONE;
                    main_load  = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (flush) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            occ_reg       <= 2'd0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != ST_TWO);
            out_valid_reg <= (state_next != ST_EMPTY);
            occ_reg       <= state_occ(state_next);
        end
    end

    // Draining TWO promotes the skid entry; every other main load takes the input.
    always_comb begin
        if (state_reg == ST_TWO) begin
            main_src_ctrl = skid_ctrl;
            main_src_addr = skid_addr;
            main_src_data = skid_data;
        end else begin
            main_src_ctrl = in_ctrl;
            main_src_addr = in_addr;
            main_src_data = in_data;
        end
    end

    pipe_payload_reg #(
        .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NDATA(NDATA)
    ) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (main_load),
        .clear_ctrl (flush),
        .in_ctrl    (main_src_ctrl),
        .in_addr    (main_src_addr),
        .in_data    (main_src_data),
        .out_ctrl   (out_ctrl),
        .out_addr   (out_addr),
        .out_data   (out_data)
    );

    pipe_payload_reg #(
        .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NDATA(NDATA)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .clear_ctrl (flush),
        .in_ctrl    (in_ctrl),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .out_ctrl   (skid_ctrl),
        .out_addr   (skid_addr),
        .out_data   (skid_data)
    );

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign occ       = occ_reg;

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Skid register bench: directed scenarios then random traffic against a queue-based scoreboard.
module tb_pipeline_skid_reg;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 4;
    localparam int ADDR_W = 5;
    localparam int NDATA  = 2;
    localparam int ENT_W  = CTRL_W + ADDR_W + NDATA*DATA_W;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    busy_wait = 1'b0;
    logic                    flush = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [CTRL_W-1:0]       in_ctrl = '0;
    logic [ADDR_W-1:0]       in_addr = '0;
    logic [NDATA*DATA_W-1:0] in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [CTRL_W-1:0]       out_ctrl;
    logic [ADDR_W-1:0]       out_addr;
    logic [NDATA*DATA_W-1:0] out_data;
    logic [1:0]              occ;

    int checks = 0;
    int errors = 0;

    pipeline_skid_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .NDATA(NDATA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy_wait (busy_wait),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: queue of entries the stage should hold, head first.
    logic [ENT_W-1:0] sb[$];
    bit               exp_in_ready = 1'b1;
    int               zero_kind = 2;   // 2: payload all zero, 1: ctrl zero, 0: unknown when empty
    bit               sb_acc, sb_em;
    logic [ENT_W-1:0] sb_head;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_occ", 64'(occ), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_payload", 64'({out_ctrl, out_addr, out_data}), 64'd0);
            sb.delete();
            exp_in_ready = 1'b1;
            zero_kind    = 2;
        end else begin
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            chk("occ", 64'(occ), 64'(sb.size()));
            chk("in_ready", 64'(in_ready), 64'(exp_in_ready));
            if (sb.size() != 0)
                chk("head", 64'({out_ctrl, out_addr, out_data}), 64'(sb[0]));
            else if (zero_kind == 2)
                chk("empty_payload", 64'({out_ctrl, out_addr, out_data}), 64'd0);
            else if (zero_kind == 1)
                chk("flush_ctrl", 64'(out_ctrl), 64'd0);

            sb_acc = in_valid && exp_in_ready && !busy_wait && !flush;
            sb_em  = (sb.size() != 0) && out_ready && !busy_wait && !flush;
            if (flush) begin
                sb.delete();
                if (zero_kind != 2) zero_kind = 1;
            end else begin
                if (sb_em) begin
                    sb_head = sb.pop_front();
                    $display("EMIT  ent=%0h", sb_head);
                end
                if (sb_acc) begin
                    if (sb.size() == 0) zero_kind = 0;
                    sb.push_back({in_ctrl, in_addr, in_data});
                    $display("ACCEPT ent=%0h", {in_ctrl, in_addr, in_data});
                end
            end
            exp_in_ready = (sb.size() != 2);
        end
    end

    // Inputs change 1 time unit after each rising edge and then hold for a full cycle.
    task automatic step(input bit v, input logic [7:0] val, input bit ordy, input bit bw, input bit fl);
        in_valid  = v;
        in_ctrl   = val[3:0] | 4'h1;
        in_addr   = val[4:0];
        in_data   = {~{8'h00, val}, {8'h00, val}};
        out_ready = ordy;
        busy_wait = bw;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back stream with downstream always ready.
        step(1, 8'h11, 1, 0, 0);
        step(1, 8'h22, 1, 0, 0);
        step(1, 8'h33, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        // Fill to two entries, then drain.
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h5a, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        // Stall with one entry held and input offered.
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h66, 1, 1, 0);
        step(1, 8'h66, 1, 1, 0);
        step(1, 8'h66, 1, 1, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        // Flush while full, with D offered and a stall asserted.
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h44, 1, 1, 1);
        step(0, 8'h00, 1, 0, 0);
        step(1, 8'h77, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        // Asynchronous reset mid-cycle while holding two entries.
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_occ", 64'(occ), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd1);
        chk("async_payload", 64'({out_ctrl, out_addr, out_data}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 8'h55, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            in_ctrl   = CTRL_W'($urandom);
            in_addr   = ADDR_W'($urandom);
            in_data   = {DATA_W'($urandom), DATA_W'($urandom)};
            out_ready = ($urandom_range(0, 99) < 60);
            busy_wait = ($urandom_range(0, 99) < 10);
            flush     = ($urandom_range(0, 99) < 2);
            @(posedge clk);
            #1;
        end

        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
